// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Takes one MIPS instruction at a time, given as a class selector plus its
//   fields, over a valid/ready handshake. It packs the instruction into a
//   32-bit word and writes that word to instruction memory at an address that
//   increments by itself. Programs can therefore be loaded without a hex file.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   clear_i      synchronous clear of address, count and error
//   valid_i      instruction fields are valid
//   ready_o      an instruction can be accepted this cycle (IDLE only)
//   op_sel_i     class: 0 R, 1 ADDI, 2 LUI, 3 ORI, 4 ANDI, 5 SW, 6 LW,
//                7 BEQ, 8 BNE, 9 J, 10 JAL, 11-15 illegal
//   rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i  instruction fields
//   mem_we_o     instruction memory write strobe (one cycle per word)
//   mem_addr_o   word address of the current write
//   mem_data_o   encoded word; holds its last value between writes
//   count_o      number of words written since reset/clear
//   full_o       MEM_DEPTH words have been written
//   err_o        sticky flag: an illegal op_sel_i was accepted
module mips_instr_encoder #(
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [3:0]          op_sel_i,
  input  logic [4:0]          rs_i,
  input  logic [4:0]          rt_i,
  input  logic [4:0]          rd_i,
  input  logic [4:0]          shamt_i,
  input  logic [5:0]          funct_i,
  input  logic [15:0]         imm_i,
  input  logic [25:0]         target_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [31:0]         mem_data_o,
  output logic [ADDR_W:0]     count_o,
  output logic                full_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(MEM_DEPTH - 1);

  state_t              state_q, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     count_q;
  logic [31:0]         data_q;
  logic                err_q;

  logic accept;
  logic legal;
  logic last_write;

  // Pack one instruction. Fields that the class does not use are dropped.
  // Immediates are passed through as given, with no sign extension.
  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sh,
    input logic [5:0]  fn,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    logic [31:0] w;
    w = 32'h0;
    case (op)
      4'd0:    w = {6'h00, rs, rt, rd, sh, fn};
      4'd1:    w = {6'h08, rs, rt, imm};
      4'd2:    w = {6'h0f, 5'd0, rt, imm};
      4'd3:    w = {6'h0d, rs, rt, imm};
      4'd4:    w = {6'h0c, rs, rt, imm};
      4'd5:    w = {6'h2b, rs, rt, imm};
      4'd6:    w = {6'h23, rs, rt, imm};
      4'd7:    w = {6'h04, rs, rt, imm};
      4'd8:    w = {6'h05, rs, rt, imm};
      4'd9:    w = {6'h02, tgt};
      4'd10:   w = {6'h03, tgt};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  assign accept     = valid_i && (state_q == S_IDLE);
  assign legal      = (op_sel_i <= 4'd10);
  assign last_write = (count_q == LAST_CNT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic; clear_i wins in every state
  always_comb begin
    state_nxt = state_q;
    if (clear_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept && legal) state_nxt = S_WRITE;
        S_WRITE: state_nxt = last_write ? S_FULL : S_IDLE;
        S_FULL:  state_nxt = S_FULL;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: depends only on state and registers, never on valid_i
  always_comb begin
    ready_o    = 1'b0;
    mem_we_o   = 1'b0;
    full_o     = 1'b0;
    case (state_q)
      S_IDLE:  ready_o  = 1'b1;
      S_WRITE: mem_we_o = 1'b1;
      S_FULL:  full_o   = 1'b1;
      default: ready_o  = 1'b0;
    endcase
    mem_addr_o = addr_q;
    mem_data_o = data_q;
    count_o    = count_q;
    err_o      = err_q;
  end

  // Address, count, word and error registers. After the last word the
  // address stays at MEM_DEPTH-1 instead of wrapping to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept && legal)
        data_q <= encode(op_sel_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i);
      if (accept && !legal)
        err_q <= 1'b1;
      if (state_q == S_WRITE) begin
        count_q <= count_q + (ADDR_W + 1)'(1);
        if (!last_write)
          addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_i;
  logic          valid_i;
  logic          ready_o;
  logic [3:0]    op_sel_i;
  logic [4:0]    rs_i, rt_i, rd_i, shamt_i;
  logic [5:0]    funct_i;
  logic [15:0]   imm_i;
  logic [25:0]   target_i;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_data_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          err_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_cnt  = 0;
  bit          m_err  = 0;
  logic [31:0] m_last = 32'h0;

  mips_instr_encoder #(.MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i),
    .ready_o(ready_o), .op_sel_i(op_sel_i), .rs_i(rs_i), .rt_i(rt_i),
    .rd_i(rd_i), .shamt_i(shamt_i), .funct_i(funct_i), .imm_i(imm_i),
    .target_i(target_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .count_o(count_o), .full_o(full_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MIPS encoding from the instruction-set tables
  function automatic logic [31:0] model_enc(input int op, input logic [4:0] rs, rt, rd, sh,
                                            input logic [5:0] fn, input logic [15:0] imm,
                                            input logic [25:0] tgt);
    logic [5:0] opc;
    case (op)
      0: opc = 6'h00;  1: opc = 6'h08;  2: opc = 6'h0f;  3: opc = 6'h0d;
      4: opc = 6'h0c;  5: opc = 6'h2b;  6: opc = 6'h23;  7: opc = 6'h04;
      8: opc = 6'h05;  9: opc = 6'h02;  default: opc = 6'h03;
    endcase
    if (op == 0)                 return {opc, rs, rt, rd, sh, fn};
    else if (op == 2)            return {opc, 5'd0, rt, imm};
    else if (op == 9 || op == 10) return {opc, tgt};
    else                         return {opc, rs, rt, imm};
  endfunction

  task automatic drive(input int op, input logic [4:0] rs, rt, rd, sh,
                       input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    op_sel_i = 4'(op); rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = sh;
    funct_i = fn; imm_i = imm; target_i = tgt; valid_i = 1'b1;
  endtask

  task automatic send(input int op, input logic [4:0] rs, rt, rd, sh,
                      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] e;
    bit full_m;
    full_m = (m_cnt == DEPTH);
    drive(op, rs, rt, rd, sh, fn, imm, tgt);
    chk("ready_before", 32'(ready_o), full_m ? 32'd0 : 32'd1);
    tick();
    valid_i = 1'b0;
    if (full_m) begin
      chk("full_no_we", 32'(mem_we_o), 0);
      chk("full_flag", 32'(full_o), 1);
      chk("full_ready", 32'(ready_o), 0);
      chk("full_err", 32'(err_o), 32'(m_err));
      chk("full_count", 32'(count_o), 32'(m_cnt));
    end else if (op > 10) begin
      m_err = 1;
      chk("illegal_no_we", 32'(mem_we_o), 0);
      chk("illegal_err", 32'(err_o), 1);
      chk("illegal_ready", 32'(ready_o), 1);
      chk("illegal_count", 32'(count_o), 32'(m_cnt));
      chk("illegal_hold", mem_data_o, m_last);
    end else begin
      e = model_enc(op, rs, rt, rd, sh, fn, imm, tgt);
      m_last = e;
      chk("wr_we", 32'(mem_we_o), 1);
      chk("wr_ready", 32'(ready_o), 0);
      chk("wr_addr", 32'(mem_addr_o), 32'(m_cnt));
      chk("wr_data", mem_data_o, e);
      tick();
      m_cnt++;
      chk("post_we", 32'(mem_we_o), 0);
      chk("post_count", 32'(count_o), 32'(m_cnt));
      chk("post_full", 32'(full_o), (m_cnt == DEPTH) ? 32'd1 : 32'd0);
      chk("post_ready", 32'(ready_o), (m_cnt == DEPTH) ? 32'd0 : 32'd1);
      chk("post_err", 32'(err_o), 32'(m_err));
      chk("post_hold", mem_data_o, m_last);
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    m_cnt = 0;
    m_err = 0;
    chk("clr_count", 32'(count_o), 0);
    chk("clr_addr", 32'(mem_addr_o), 0);
    chk("clr_err", 32'(err_o), 0);
    chk("clr_full", 32'(full_o), 0);
    chk("clr_ready", 32'(ready_o), 1);
    chk("clr_we", 32'(mem_we_o), 0);
  endtask

  initial begin
    reset = 1'b0; clear_i = 1'b0; valid_i = 1'b0;
    op_sel_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; shamt_i = '0;
    funct_i = '0; imm_i = '0; target_i = '0;
    tick();
    tick();
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_addr", 32'(mem_addr_o), 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_err", 32'(err_o), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Directed words, filling the four-word memory
    send(1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0);
    chk("addi_word", mem_data_o, 32'h20220005);
    send(0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    chk("rtype_word", mem_data_o, 32'h00221820);
    send(9, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0100000);
    chk("j_word", mem_data_o, 32'h08100000);
    send(2, 5'd7, 5'd1, 5'd0, 5'd0, 6'h00, 16'h1001, 26'h0);
    chk("lui_word", mem_data_o, 32'h3C011001);
    // Full: further requests, legal or illegal, are ignored
    send(1, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0);
    send(12, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0);
    do_clear();

    // Illegal selector then a legal one
    send(12, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'hffff, 26'h3ffffff);
    send(3, 5'd9, 5'd10, 5'd0, 5'd0, 6'h00, 16'h00ff, 26'h0);
    chk("err_sticky", 32'(err_o), 1);

    // clear_i during WRITE: strobe completes, count not incremented
    drive(4, 5'd5, 5'd6, 5'd0, 5'd0, 6'h00, 16'h0f0f, 26'h0);
    tick();
    valid_i = 1'b0;
    m_last = model_enc(4, 5'd5, 5'd6, 5'd0, 5'd0, 6'h00, 16'h0f0f, 26'h0);
    clear_i = 1'b1;
    chk("cw_we", 32'(mem_we_o), 1);
    chk("cw_addr", 32'(mem_addr_o), 1);
    chk("cw_data", mem_data_o, m_last);
    tick();
    clear_i = 1'b0;
    m_cnt = 0;
    m_err = 0;
    chk("cw_count", 32'(count_o), 0);
    chk("cw_addr0", 32'(mem_addr_o), 0);
    chk("cw_we_off", 32'(mem_we_o), 0);
    chk("cw_err", 32'(err_o), 0);
    chk("cw_ready", 32'(ready_o), 1);

    // Randomized instructions against the model
    for (int i = 0; i < 80; i++) begin
      if (m_cnt == DEPTH && $urandom_range(0, 1) == 1) begin
        do_clear();
      end else begin
        send(int'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    do_clear();

    // Reset asserted in the middle of a WRITE cycle
    drive(6, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h0040, 26'h0);
    tick();
    valid_i = 1'b0;
    chk("rw_we", 32'(mem_we_o), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_we_async", 32'(mem_we_o), 0);
    chk("rw_ready", 32'(ready_o), 1);
    chk("rw_count", 32'(count_o), 0);
    chk("rw_addr", 32'(mem_addr_o), 0);
    chk("rw_data", mem_data_o, 0);
    chk("rw_full", 32'(full_o), 0);
    chk("rw_err", 32'(err_o), 0);
    tick();
    chk("rw_count_held", 32'(count_o), 0);
    @(negedge clk);
    reset = 1'b1;
    m_cnt = 0; m_err = 0; m_last = 32'h0;
    tick();
    send(10, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h2abcdef);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
